// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The lane helper is used by both the request and response steering paths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    localparam int LANES = 4;

    // Access is rejected when it crosses its natural boundary or uses the reserved width code.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        logic bad;
        case (width)
            WIDTH_B: bad = 1'b0;
            WIDTH_H: bad = off[0];
            WIDTH_W: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit memory: store-side byte enables and data replication,
// load-side right alignment with zero extension, and alignment checking of new requests.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_req_width,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_req_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_rsp_width,
    input  logic [1:0]  i_rsp_off,
    input  logic [31:0] i_rsp_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0] w_rsp_byte [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_rsp_byte[gi] = i_rsp_rdata[8*gi +: 8];
        end
    endgenerate

    assign o_misaligned = is_misaligned(i_req_width, i_req_off);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_req_wdata;
        case (i_req_width)
            WIDTH_B: begin
                o_be    = 4'b0001 << i_req_off;
                o_wdata = {4{i_req_wdata[7:0]}};
            end
            WIDTH_H: begin
                o_be    = 4'b0011 << i_req_off;
                o_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_req_wdata;
            end
        endcase
    end

    always_comb begin
        o_rdata = i_rsp_rdata;
        case (i_rsp_width)
            WIDTH_B: o_rdata = {24'd0, w_rsp_byte[i_rsp_off]};
            WIDTH_H: o_rdata = i_rsp_off[1] ? {16'd0, w_rsp_byte[3], w_rsp_byte[2]}
                                            : {16'd0, w_rsp_byte[1], w_rsp_byte[0]};
            default: o_rdata = i_rsp_rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory with one
// transaction outstanding; data wins unless fetch has waited through a full data streak.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_misaligned,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0]        STREAK_MAX = 4'(MAX_DATA_BURST);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    owner_t            r_owner;
    logic [3:0]        r_streak;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_rsp_width;
    logic [1:0]        r_rsp_off;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_data_first;
    logic              w_grant_d;
    logic              w_grant_f;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata_steered;
    logic [DATA_W-1:0] w_rdata_steered;
    logic              w_misaligned;
    logic [3:0]        w_streak_inc;

    mem_lane_align u_lane_align (
        .i_req_width (d_width),
        .i_req_off   (d_addr[1:0]),
        .i_req_wdata (d_wdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata_steered),
        .o_misaligned(w_misaligned),
        .i_rsp_width (r_rsp_width),
        .i_rsp_off   (r_rsp_off),
        .i_rsp_rdata (mem_rdata),
        .o_rdata     (w_rdata_steered)
    );

    // Fetch overrides data only once data has won MAX_DATA_BURST times in a row.
    assign w_data_first = d_req && !(if_req && (r_streak == STREAK_MAX));
    assign w_streak_inc = (r_streak == STREAK_MAX) ? r_streak : r_streak + 4'd1;

    always_comb begin
        w_state_next = r_state;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        d_misaligned = 1'b0;
        w_grant_d    = 1'b0;
        w_grant_f    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_data_first) begin
                    d_gnt = 1'b1;
                    if (w_misaligned) begin
                        d_misaligned = 1'b1;
                    end else begin
                        w_grant_d    = 1'b1;
                        w_state_next = ISSUE;
                    end
                end else if (if_req) begin
                    if_gnt       = 1'b1;
                    w_grant_f    = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: if (mem_gnt) w_state_next = WAIT;
            WAIT:  if (mem_rvalid) w_state_next = RESP;
            RESP:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= FETCH;
            r_streak    <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= 4'd0;
            r_wdata     <= '0;
            r_rsp_width <= WIDTH_W;
            r_rsp_off   <= 2'd0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_d) begin
                r_owner     <= DATA;
                r_streak    <= w_streak_inc;
                r_we        <= d_we;
                r_addr      <= d_addr & WORD_MASK;
                r_be        <= d_we ? w_be : 4'b1111;
                r_wdata     <= d_we ? w_wdata_steered : '0;
                r_rsp_width <= d_width;
                r_rsp_off   <= d_addr[1:0];
            end else if (w_grant_f) begin
                r_owner     <= FETCH;
                r_streak    <= 4'd0;
                r_we        <= 1'b0;
                r_addr      <= if_addr & WORD_MASK;
                r_be        <= 4'b1111;
                r_wdata     <= '0;
                r_rsp_width <= WIDTH_W;
                r_rsp_off   <= 2'd0;
            end
            // Responses are only taken in WAIT, so a stale ack after reset is dropped.
            if (r_state == WAIT && mem_rvalid) begin
                if (r_owner == FETCH) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_d_rdata <= r_we ? '0 : w_rdata_steered;
                end
            end
        end
    end

    assign mem_req   = (r_state == ISSUE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

    assign if_rvalid = (r_state == RESP) && (r_owner == FETCH);
    assign d_rvalid  = (r_state == RESP) && (r_owner == DATA);
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lane steering, arbitration fairness, rejection of
// misaligned accesses, memory stalls and reset while a transaction is in flight.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  d_width = 2'b00;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_misaligned, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_misaligned(d_misaligned), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] flags;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        flags = {if_gnt, if_rvalid, d_gnt, d_misaligned, d_rvalid, mem_req, mem_we,
                 |mem_addr, |mem_be, |mem_wdata, |if_rdata, |d_rdata};
        checks++;
        if (flags !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs: got flags %b expected %b", flags, 12'd0);
        end
        $display("reset: outputs flags=%b", flags);
        step();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        #1;
        checks++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            failures++; $display("FAIL fetch_gnt: got %b expected %b", {if_gnt, d_gnt}, 2'b10);
        end
        step();
        if_req = 1'b0; if_addr = '0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, if_rvalid} !== {1'b1, 1'b0, 4'hF, 32'h104, 1'b0}) begin
            failures++;
            $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h rv=%b expected 1 0 f 00000104 0",
                     mem_req, mem_we, mem_be, mem_addr, if_rvalid);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
        #1;
        checks++;
        if ({mem_req, if_rvalid} !== 2'b00) begin
            failures++; $display("FAIL fetch_wait: got req/rvalid %b expected 00", {mem_req, if_rvalid});
        end
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if ({if_rvalid, d_rvalid, if_rdata} !== {1'b1, 1'b0, 32'h0010_0093}) begin
            failures++;
            $display("FAIL fetch_resp: got if_rv=%b d_rv=%b rdata=%h expected 1 0 00100093",
                     if_rvalid, d_rvalid, if_rdata);
        end
        step();
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h0010_0093}) begin
            failures++;
            $display("FAIL fetch_hold: got rv=%b rdata=%h expected 0 00100093", if_rvalid, if_rdata);
        end
        $display("fetch: addr=104 rdata=%h", if_rdata);
    endtask

    task automatic test_data_xact(input string name, input logic we, input logic [1:0] width,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] mrdata, input logic [31:0] exp_addr,
                                  input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                  input logic [31:0] exp_rdata);
        d_req = 1'b1; d_we = we; d_width = width; d_addr = addr; d_wdata = wdata;
        #1;
        checks++;
        if ({d_gnt, d_misaligned, if_gnt} !== 3'b100) begin
            failures++;
            $display("FAIL %s_gnt: got gnt/mis/if_gnt %b expected 100", name, {d_gnt, d_misaligned, if_gnt});
        end
        step();
        d_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, we, exp_addr, exp_be}) begin
            failures++;
            $display("FAIL %s_issue: got req=%b we=%b addr=%h be=%b expected 1 %b %h %b",
                     name, mem_req, mem_we, mem_addr, mem_be, we, exp_addr, exp_be);
        end
        if (we) begin
            checks++;
            if (mem_wdata !== exp_wdata) begin
                failures++; $display("FAIL %s_wdata: got %h expected %h", name, mem_wdata, exp_wdata);
            end
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = mrdata;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if ({d_rvalid, if_rvalid, d_rdata} !== {1'b1, 1'b0, exp_rdata}) begin
            failures++;
            $display("FAIL %s_resp: got d_rv=%b if_rv=%b rdata=%h expected 1 0 %h",
                     name, d_rvalid, if_rvalid, d_rdata, exp_rdata);
        end
        $display("%s: addr=%h be=%b wdata=%h rdata=%h", name, exp_addr, exp_be, exp_wdata, d_rdata);
        step();
    endtask

    task automatic test_lanes();
        test_data_xact("byte_store_203", 1'b1, 2'b00, 32'h203, 32'h0000_00AB, 32'hFFFF_FFFF,
                       32'h200, 4'b1000, 32'hABAB_ABAB, 32'h0);
        test_data_xact("half_load_202", 1'b0, 2'b01, 32'h202, 32'h0, 32'hBEEF_1234,
                       32'h200, 4'b1111, 32'h0, 32'h0000_BEEF);
        test_data_xact("half_load_200", 1'b0, 2'b01, 32'h200, 32'h0, 32'hBEEF_1234,
                       32'h200, 4'b1111, 32'h0, 32'h0000_1234);
        test_data_xact("byte_load_201", 1'b0, 2'b00, 32'h201, 32'h0, 32'h1122_3344,
                       32'h200, 4'b1111, 32'h0, 32'h0000_0033);
        test_data_xact("half_store_106", 1'b1, 2'b01, 32'h106, 32'h5555_1234, 32'h0,
                       32'h104, 4'b1100, 32'h1234_1234, 32'h0);
        test_data_xact("byte_store_100", 1'b1, 2'b00, 32'h100, 32'h0000_001C, 32'h0,
                       32'h100, 4'b0001, 32'h1C1C_1C1C, 32'h0);
        test_data_xact("word_store_300", 1'b1, 2'b10, 32'h300, 32'hDEAD_BEEF, 32'h0,
                       32'h300, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        test_data_xact("word_load_304", 1'b0, 2'b10, 32'h304, 32'h0, 32'hCAFE_F00D,
                       32'h304, 4'b1111, 32'h0, 32'hCAFE_F00D);
    endtask

    // Complete one already-granted transaction with zero-wait memory.
    task automatic serve_one();
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        string expected = "DDDDFDDDDF";
        byte   got;
        int    n;
        rst = 1'b1; step(); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h800;
        d_req = 1'b1; d_we = 1'b0; d_width = 2'b10; d_addr = 32'h900;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            #1;
            while (!if_gnt && !d_gnt && n < 20) begin
                step(); #1; n++;
            end
            got = d_gnt ? "D" : (if_gnt ? "F" : "-");
            checks++;
            if (got !== expected[i]) begin
                failures++;
                $display("FAIL starve_grant_%0d: got %c expected %c", i, got, expected[i]);
            end
            $display("starvation: grant %0d = %c", i, got);
            serve_one();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [1:0] widths [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h100};
        int seen;
        byte got;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++)
            test_data_xact("warmup_load", 1'b0, 2'b10, 32'h900, 32'h0, 32'h0000_0042,
                           32'h900, 4'b1111, 32'h0, 32'h0000_0042);
        for (int k = 0; k < 3; k++) begin
            d_req = 1'b1; d_we = 1'b0; d_width = widths[k]; d_addr = addrs[k];
            #1;
            checks++;
            if ({d_gnt, d_misaligned, if_gnt} !== 3'b110) begin
                failures++;
                $display("FAIL misalign_pulse_%0d: got gnt/mis/if_gnt %b expected 110",
                         k, {d_gnt, d_misaligned, if_gnt});
            end
            step();
            d_req = 1'b0;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (mem_req || d_rvalid || d_misaligned) seen++;
                step();
            end
            checks++;
            if (seen !== 0) begin
                failures++; $display("FAIL misalign_quiet_%0d: got %0d busy cycles expected 0", k, seen);
            end
            $display("misaligned: width=%b addr=%h rejected, busy cycles=%0d", widths[k], addrs[k], seen);
        end
        // Streak is 3 here: one more data grant must precede the forced fetch.
        if_req = 1'b1; if_addr = 32'h800;
        d_req = 1'b1; d_we = 1'b0; d_width = 2'b10; d_addr = 32'h900;
        for (int i = 0; i < 2; i++) begin
            #1;
            got = d_gnt ? "D" : (if_gnt ? "F" : "-");
            checks++;
            if (got !== ((i == 0) ? "D" : "F")) begin
                failures++;
                $display("FAIL misalign_streak_%0d: got %c expected %c", i, got, (i == 0) ? "D" : "F");
            end
            serve_one();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_stall();
        int rv_count = 0;
        int bad = 0;
        if_req = 1'b1; if_addr = 32'h500;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++; $display("FAIL stall_gnt: got %b expected 1", if_gnt);
        end
        step();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_width = 2'b10; d_addr = 32'h900;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid = (i == 2);
            mem_rdata  = (i == 2) ? 32'h0000_0BAD : 32'h0;
            mem_gnt    = (i == 5);
            #1;
            if (!mem_req || mem_addr !== 32'h500 || if_gnt || d_gnt) bad++;
            if (if_rvalid || d_rvalid) rv_count++;
            step();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 1; i <= 4; i++) begin
            mem_rvalid = (i == 3);
            mem_rdata  = (i == 3) ? 32'h1357_9BDF : 32'h0;
            #1;
            if (mem_req || if_gnt || d_gnt) bad++;
            if (if_rvalid || d_rvalid) rv_count++;
            if (i == 4) d_req = 1'b0;
            step();
        end
        mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (if_rvalid || d_rvalid) rv_count++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL stall_stable: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (rv_count !== 1) begin
            failures++; $display("FAIL stall_rvalid_count: got %0d expected 1", rv_count);
        end
        checks++;
        if (if_rdata !== 32'h1357_9BDF) begin
            failures++; $display("FAIL stall_rdata: got %h expected 13579bdf", if_rdata);
        end
        $display("stall: bad=%0d rvalid_pulses=%0d rdata=%h", bad, rv_count, if_rdata);
    endtask

    task automatic test_reset_mid_wait();
        int rv_count = 0;
        if_req = 1'b1; if_addr = 32'h600;
        step();
        if_req = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_600D;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, if_rdata} !== {1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
            failures++;
            $display("FAIL rst_wait_outputs: got req=%b we=%b addr=%h be=%h if_rdata=%h expected all 0",
                     mem_req, mem_we, mem_addr, mem_be, if_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            mem_rvalid = 1'b0; mem_rdata = '0;
            #1;
            if (if_rvalid || d_rvalid) rv_count++;
        end
        checks++;
        if (rv_count !== 0 || if_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_wait_ignored: got %0d rvalids rdata=%h expected 0 00000000", rv_count, if_rdata);
        end
        step();
        if_req = 1'b1; if_addr = 32'h700;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++; $display("FAIL rst_wait_regrant: got %b expected 1", if_gnt);
        end
        step();
        if_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
            failures++; $display("FAIL rst_wait_reissue: got req=%b addr=%h expected 1 00000700", mem_req, mem_addr);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0513;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000_0513}) begin
            failures++; $display("FAIL rst_wait_refetch: got rv=%b rdata=%h expected 1 00000513", if_rvalid, if_rdata);
        end
        $display("reset_mid_wait: stale rvalids=%0d refetch rdata=%h", rv_count, if_rdata);
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_lanes();
        test_starvation();
        test_misaligned();
        test_stall();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
